branch_resolve_unit: RTL and testbench

//  Execute-side end of the fetch predictor interface. Takes two resolved branch results per cycle
//  (lane 0 older) and classifies each as correct, mispredict, not-a-branch or nothing.

---
 rtl/branch_resolve_unit_pkg.sv | 52 +++++
 rtl/branch_resolve_unit_update_fifo.sv | 59 +++++
 rtl/branch_resolve_unit.sv | 138 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: record kinds, update record layout, FSM states.
package branch_resolve_unit_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned BRU_KIND_W = 2;

  // Record classification; NONE never enters the FIFO
  typedef enum logic [BRU_KIND_W-1:0] {
    BRU_KIND_NONE = 2'd0,
    BRU_KIND_OK   = 2'd1,
    BRU_KIND_MISP = 2'd2,
    BRU_KIND_WNB  = 2'd3
  } bru_kind_e;

  // Predictor-update / redirect record
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
    logic            taken;
    bru_kind_e       kind;
  } bru_entry_t;

  localparam int unsigned BRU_ENTRY_W = $bits(bru_entry_t);

  typedef enum logic {
    BRU_ST_ACCEPT = 1'b0,
    BRU_ST_SQUASH = 1'b1
  } bru_state_e;

  // Classify one resolved lane result
  function automatic bru_kind_e bru_classify(input logic            is_br,
                                             input logic            taken,
                                             input logic [XLEN-1:0] tgt,
                                             input logic            pred,
                                             input logic [XLEN-1:0] ptgt);
    bru_kind_e k;
    k = BRU_KIND_NONE;
    if (is_br) begin
      if ((taken != pred) || (taken && (tgt != ptgt))) k = BRU_KIND_MISP;
      else                                             k = BRU_KIND_OK;
    end else if (pred) begin
      k = BRU_KIND_WNB;
    end
    return k;
  endfunction

  // Records that force fetch to change course
  function automatic logic bru_is_redirect(input bru_kind_e k);
    return (k == BRU_KIND_MISP) || (k == BRU_KIND_WNB);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_update_fifo.sv
// Update-record FIFO: DEPTH entries, up to two pushes and one pop per cycle, count output.
module branch_resolve_unit_update_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic [1:0]                   push_cnt_i,
  input  bru_entry_t                   push_data0_i,
  input  bru_entry_t                   push_data1_i,
  input  logic                         pop_i,
  output bru_entry_t                   head_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  bru_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_p1;
  logic          pop;

  // Pointer arithmetic; pointers carry one wrap bit so full and empty are distinct
  always_comb begin
    pop     = pop_i && !empty_o;
    wptr_p1 = wptr_q + PW'(1);
    wptr_d  = wptr_q + PW'(push_cnt_i);
    rptr_d  = rptr_q + PW'(pop);
  end

  // Pointer registers
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage writes in age order; contents need no reset since empty masks the head
  always_ff @(posedge clock_i) begin
    if (push_cnt_i != 2'd0) mem_q[wptr_q[AW-1:0]]  <= push_data0_i;
    if (push_cnt_i == 2'd2) mem_q[wptr_p1[AW-1:0]] <= push_data1_i;
  end

  // Status and head presentation
  always_comb begin
    empty_o = (wptr_q == rptr_q);
    count_o = wptr_q - rptr_q;
    head_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: classifies two resolved lanes, queues update/redirect records for fetch1.
// Optional BRU_STATS_EN adds popped-branch and popped-mispredict counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            res_valid_0_i,
  input  logic [XLEN-1:0] res_pc_0_i,
  input  logic            res_is_br_0_i,
  input  logic            res_taken_0_i,
  input  logic [XLEN-1:0] res_tgt_0_i,
  input  logic            res_pred_0_i,
  input  logic [XLEN-1:0] res_ptgt_0_i,
  input  logic            res_valid_1_i,
  input  logic [XLEN-1:0] res_pc_1_i,
  input  logic            res_is_br_1_i,
  input  logic            res_taken_1_i,
  input  logic [XLEN-1:0] res_tgt_1_i,
  input  logic            res_pred_1_i,
  input  logic [XLEN-1:0] res_ptgt_1_i,
  input  logic            pc_we_i,
  output logic            res_ready_o,
  output logic [XLEN-1:0] update_pc_o,
  output logic [XLEN-1:0] update_tgt_o,
  output logic            last_br_o,
  output logic            update_pht_o,
  output logic            update_btb_o,
  output logic            wrong_pred_o,
  output logic [XLEN-1:0] fixed_pc_o,
  output logic            wasnt_branch_o,
  output logic [XLEN-1:0] wasnt_br_pc_o,
`ifdef BRU_STATS_EN
  output logic [XLEN-1:0] stat_branches_o,
  output logic [XLEN-1:0] stat_mispred_o,
`endif
  output logic            flush_o
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;

  bru_state_e    state_q, state_d;
  bru_kind_e     kind0, kind1;
  bru_entry_t    rec0, rec1, push0, push1, head;
  logic          has0, has1, redir_push, empty, pop, room;
  logic [1:0]    push_cnt;
  logic [PW-1:0] count;

  // Lane classification, lane-0 redirect suppression and age-ordered push packing
  always_comb begin
    kind0 = bru_classify(res_is_br_0_i, res_taken_0_i, res_tgt_0_i, res_pred_0_i, res_ptgt_0_i);
    kind1 = bru_classify(res_is_br_1_i, res_taken_1_i, res_tgt_1_i, res_pred_1_i, res_ptgt_1_i);
    rec0  = '{pc: res_pc_0_i, tgt: res_tgt_0_i, taken: res_taken_0_i, kind: kind0};
    rec1  = '{pc: res_pc_1_i, tgt: res_tgt_1_i, taken: res_taken_1_i, kind: kind1};
    has0  = res_ready_o && res_valid_0_i && (kind0 != BRU_KIND_NONE);
    has1  = res_ready_o && res_valid_1_i && (kind1 != BRU_KIND_NONE) &&
            !(has0 && bru_is_redirect(kind0));
    push_cnt   = 2'(has0) + 2'(has1);
    push0      = has0 ? rec0 : rec1;
    push1      = rec1;
    redir_push = (has0 && bru_is_redirect(kind0)) || (has1 && bru_is_redirect(kind1));
    pop        = pc_we_i && !empty;
    room       = (count <= PW'(DEPTH - 2));
  end

  branch_resolve_unit_update_fifo #(
    .DEPTH (DEPTH)
  ) u_bru_update_fifo (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .push_cnt_i   (push_cnt),
    .push_data0_i (push0),
    .push_data1_i (push1),
    .pop_i        (pc_we_i),
    .head_o       (head),
    .empty_o      (empty),
    .count_o      (count)
  );

  // FSM state register
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) state_q <= BRU_ST_ACCEPT;
    else          state_q <= state_d;
  end

  // FSM next state: squash from redirect push until that redirect pops
  always_comb begin
    state_d = state_q;
    case (state_q)
      BRU_ST_ACCEPT: if (redir_push) state_d = BRU_ST_SQUASH;
      BRU_ST_SQUASH: if (flush_o)    state_d = BRU_ST_ACCEPT;
      default:                       state_d = BRU_ST_ACCEPT;
    endcase
  end

  // FSM outputs: intake handshake and flush pulse on the redirect pop
  always_comb begin
    res_ready_o = 1'b0;
    flush_o     = 1'b0;
    if (reset_i && (state_q == BRU_ST_ACCEPT) && room) res_ready_o = 1'b1;
    if ((state_q == BRU_ST_SQUASH) && pop && bru_is_redirect(head.kind)) flush_o = 1'b1;
  end

  // Head record decode; head is all-zero when the FIFO is empty
  always_comb begin
    update_pc_o    = head.pc;
    update_tgt_o   = head.tgt;
    last_br_o      = head.taken;
    update_pht_o   = (head.kind == BRU_KIND_OK) || (head.kind == BRU_KIND_MISP);
    update_btb_o   = update_pht_o && head.taken;
    wrong_pred_o   = (head.kind == BRU_KIND_MISP);
    wasnt_branch_o = (head.kind == BRU_KIND_WNB);
    wasnt_br_pc_o  = wasnt_branch_o ? head.pc : '0;
    fixed_pc_o     = '0;
    if (!empty) fixed_pc_o = head.taken ? head.tgt : (head.pc + XLEN'(4));
  end

`ifdef BRU_STATS_EN
  logic [XLEN-1:0] stat_br_q, stat_mp_q;

  // Saturating counters of popped branch and popped redirect records
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (pop) begin
      if (update_pht_o && (stat_br_q != '1))               stat_br_q <= stat_br_q + XLEN'(1);
      if (bru_is_redirect(head.kind) && (stat_mp_q != '1)) stat_mp_q <= stat_mp_q + XLEN'(1);
    end
  end

  assign stat_branches_o = stat_br_q;
  assign stat_mispred_o  = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit; stats checks compile in with BRU_STATS_EN.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        res_valid_0_i, res_is_br_0_i, res_taken_0_i, res_pred_0_i;
  logic [31:0] res_pc_0_i, res_tgt_0_i, res_ptgt_0_i;
  logic        res_valid_1_i, res_is_br_1_i, res_taken_1_i, res_pred_1_i;
  logic [31:0] res_pc_1_i, res_tgt_1_i, res_ptgt_1_i;
  logic        pc_we_i = 1'b0;
  logic        res_ready_o, last_br_o, update_pht_o, update_btb_o, wrong_pred_o;
  logic        wasnt_branch_o, flush_o;
  logic [31:0] update_pc_o, update_tgt_o, fixed_pc_o, wasnt_br_pc_o;
`ifdef BRU_STATS_EN
  logic [31:0] stat_branches_o, stat_mispred_o;
`endif

  int total = 0;
  int bad   = 0;

  branch_resolve_unit #(.DEPTH(4)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .res_valid_0_i(res_valid_0_i), .res_pc_0_i(res_pc_0_i), .res_is_br_0_i(res_is_br_0_i),
    .res_taken_0_i(res_taken_0_i), .res_tgt_0_i(res_tgt_0_i), .res_pred_0_i(res_pred_0_i),
    .res_ptgt_0_i(res_ptgt_0_i),
    .res_valid_1_i(res_valid_1_i), .res_pc_1_i(res_pc_1_i), .res_is_br_1_i(res_is_br_1_i),
    .res_taken_1_i(res_taken_1_i), .res_tgt_1_i(res_tgt_1_i), .res_pred_1_i(res_pred_1_i),
    .res_ptgt_1_i(res_ptgt_1_i),
    .pc_we_i(pc_we_i), .res_ready_o(res_ready_o),
    .update_pc_o(update_pc_o), .update_tgt_o(update_tgt_o), .last_br_o(last_br_o),
    .update_pht_o(update_pht_o), .update_btb_o(update_btb_o), .wrong_pred_o(wrong_pred_o),
    .fixed_pc_o(fixed_pc_o), .wasnt_branch_o(wasnt_branch_o), .wasnt_br_pc_o(wasnt_br_pc_o),
`ifdef BRU_STATS_EN
    .stat_branches_o(stat_branches_o), .stat_mispred_o(stat_mispred_o),
`endif
    .flush_o(flush_o)
  );

  always #5 clock_i = ~clock_i;

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ln, input logic v, input logic [31:0] pc, input logic br,
                       input logic tk, input logic [31:0] tgt, input logic pr,
                       input logic [31:0] pt);
    if (ln == 0) begin
      res_valid_0_i = v; res_pc_0_i = pc; res_is_br_0_i = br; res_taken_0_i = tk;
      res_tgt_0_i = tgt; res_pred_0_i = pr; res_ptgt_0_i = pt;
    end else begin
      res_valid_1_i = v; res_pc_1_i = pc; res_is_br_1_i = br; res_taken_1_i = tk;
      res_tgt_1_i = tgt; res_pred_1_i = pr; res_ptgt_1_i = pt;
    end
  endtask

  task automatic clr();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    clr();
    // Reset state
    step(); step();
    chk("rst_ready_low", 32'(res_ready_o), 0);
    chk("rst_update_pc", update_pc_o, 0);
    chk("rst_fixed_pc", fixed_pc_o, 0);
    reset_i = 1'b1;
    #1;
    chk("rst_ready_after", 32'(res_ready_o), 1);
    step();

    // 1: OK not-taken; pop on the following edge
    drive(0, 1, 32'h40, 1, 0, 0, 0, 0);
    pc_we_i = 1'b1;
    step();
    clr();
    chk("t1_pht", 32'(update_pht_o), 1);
    chk("t1_last_br", 32'(last_br_o), 0);
    chk("t1_btb", 32'(update_btb_o), 0);
    chk("t1_wrong", 32'(wrong_pred_o), 0);
    chk("t1_pc", update_pc_o, 32'h40);
    chk("t1_fixed", fixed_pc_o, 32'h44);
    step();
    pc_we_i = 1'b0;
    chk("t1_empty_pht", 32'(update_pht_o), 0);
    chk("t1_empty_pc", update_pc_o, 0);

    // 2: lane-0 mispredict drops lane 1; squash until pop
    drive(0, 1, 32'h100, 1, 1, 32'h200, 0, 0);
    drive(1, 1, 32'h104, 1, 0, 0, 0, 0);
    step();
    chk("t2_wrong", 32'(wrong_pred_o), 1);
    chk("t2_fixed", fixed_pc_o, 32'h200);
    chk("t2_btb", 32'(update_btb_o), 1);
    chk("t2_ready", 32'(res_ready_o), 0);
    chk("t2_no_flush", 32'(flush_o), 0);
    drive(0, 1, 32'h300, 1, 0, 0, 0, 0);
    step();
    chk("t2_hold_pc", update_pc_o, 32'h100);
    chk("t2_hold_ready", 32'(res_ready_o), 0);
    clr();
    pc_we_i = 1'b1;
    #1;
    chk("t2_flush", 32'(flush_o), 1);
    step();
    pc_we_i = 1'b0;
    chk("t2_after_pc", update_pc_o, 0);
    chk("t2_after_flush", 32'(flush_o), 0);
    chk("t2_after_ready", 32'(res_ready_o), 1);

    // 3: predicted-taken non-branch
    drive(0, 1, 32'h80, 0, 0, 0, 1, 32'h999);
    step();
    clr();
    chk("t3_wnb", 32'(wasnt_branch_o), 1);
    chk("t3_wnb_pc", wasnt_br_pc_o, 32'h80);
    chk("t3_pht", 32'(update_pht_o), 0);
    chk("t3_wrong", 32'(wrong_pred_o), 0);
    chk("t3_fixed", fixed_pc_o, 32'h84);
    chk("t3_ready", 32'(res_ready_o), 0);
    pc_we_i = 1'b1;
    #1;
    chk("t3_flush", 32'(flush_o), 1);
    step();
    pc_we_i = 1'b0;
    chk("t3_after_wnb", 32'(wasnt_branch_o), 0);
    chk("t3_after_ready", 32'(res_ready_o), 1);

    // 4: fill, ordering, push+pop same cycle
    drive(0, 1, 32'h10, 1, 0, 0, 0, 0);
    drive(1, 1, 32'h14, 1, 0, 0, 0, 0);
    step();
    chk("t4_ready_2", 32'(res_ready_o), 1);
    drive(0, 1, 32'h18, 1, 0, 0, 0, 0);
    drive(1, 1, 32'h1C, 1, 0, 0, 0, 0);
    step();
    clr();
    chk("t4_ready_full", 32'(res_ready_o), 0);
    chk("t4_head0", update_pc_o, 32'h10);
    pc_we_i = 1'b1;
    step();
    chk("t4_head1", update_pc_o, 32'h14);
    chk("t4_ready_3", 32'(res_ready_o), 0);
    step();
    chk("t4_head2", update_pc_o, 32'h18);
    chk("t4_ready_2b", 32'(res_ready_o), 1);
    drive(0, 1, 32'h20, 1, 0, 0, 0, 0);
    step();
    clr();
    chk("t4_pushpop_head", update_pc_o, 32'h1C);
    chk("t4_pushpop_ready", 32'(res_ready_o), 1);
    step();
    chk("t4_head4", update_pc_o, 32'h20);
    step();
    pc_we_i = 1'b0;
    chk("t4_drained", update_pc_o, 0);
    // lane-1-only record and fixed_pc wrap
    drive(1, 1, 32'h50, 1, 0, 0, 0, 0);
    step();
    clr();
    chk("t4_lane1_only", update_pc_o, 32'h50);
    pc_we_i = 1'b1;
    step();
    pc_we_i = 1'b0;
    drive(0, 1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0);
    step();
    clr();
    chk("t4_wrap", fixed_pc_o, 32'h0);
    pc_we_i = 1'b1;
    step();
    pc_we_i = 1'b0;
    chk("t4_wrap_drained", update_pc_o, 0);

    // 5: asynchronous reset with records queued
    drive(0, 1, 32'h60, 1, 0, 0, 0, 0);
    drive(1, 1, 32'h64, 1, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h68, 1, 0, 0, 0, 0);
    step();
    clr();
    chk("t5_head", update_pc_o, 32'h60);
    #3;
    reset_i = 1'b0;
    #1;
    chk("t5_pc_in_reset", update_pc_o, 0);
    chk("t5_ready_in_reset", 32'(res_ready_o), 0);
    step();
    reset_i = 1'b1;
    #1;
    chk("t5_ready_release", 32'(res_ready_o), 1);
    chk("t5_empty", update_pc_o, 0);
    step();

`ifdef BRU_STATS_EN
    // 6: stats over 3 OK, 1 MISP, 1 WNB pops
    drive(0, 1, 32'hA0, 1, 0, 0, 0, 0);
    drive(1, 1, 32'hA4, 1, 0, 0, 0, 0);
    step();
    drive(0, 1, 32'hA8, 1, 0, 0, 0, 0);
    drive(1, 1, 32'hAC, 1, 1, 32'h300, 0, 0);
    step();
    clr();
    pc_we_i = 1'b1;
    repeat (4) step();
    pc_we_i = 1'b0;
    drive(0, 1, 32'hB0, 0, 0, 0, 1, 0);
    step();
    clr();
    pc_we_i = 1'b1;
    step();
    pc_we_i = 1'b0;
    chk("t6_branches", stat_branches_o, 4);
    chk("t6_mispred", stat_mispred_o, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
